// File: rtl/quiz_pkg.sv
// Shared types and helpers for the quiz buzzer arbiter.
// State encoding and a width helper safe for small player counts.
package quiz_pkg;

    localparam logic [1:0] ENC_IDLE    = 2'd0;
    localparam logic [1:0] ENC_ARMED   = 2'd1;
    localparam logic [1:0] ENC_LOCKED  = 2'd2;
    localparam logic [1:0] ENC_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ENC_IDLE,
        ST_ARMED   = ENC_ARMED,
        ST_LOCKED  = ENC_LOCKED,
        ST_TIMEOUT = ENC_TIMEOUT
    } state_t;

    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/quiz_rr_pick.sv
// Combinational rotating-priority picker.
// Grants the first request at or above ptr, wrapping modulo N.
module quiz_rr_pick
    import quiz_pkg::*;
#(
    parameter int N   = 8,
    parameter int IDW = clog2_safe(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt_onehot,
    output logic [IDW-1:0] gnt_id,
    output logic           any
);

    logic [IDW-1:0] idx;

    // scan from ptr upward, first hit wins
    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        any        = 1'b0;
        idx        = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDW'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_id          = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/quiz_buzzer_arbiter.sv
// N-player fastest-finger-first arbiter with rotating tie-break.
// Optional false-start disqualification: QUIZ_FALSE_START_EN.
module quiz_buzzer_arbiter
    import quiz_pkg::*;
#(
    parameter int N_PLAYERS      = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int IDW            = clog2_safe(N_PLAYERS)
) (
    input  logic                 clk,
    input  logic                 preset,
    input  logic                 arm,
    input  logic                 clear,
    input  logic [N_PLAYERS-1:0] btn,
    output logic [1:0]           state,
    output logic                 winner_valid,
    output logic [IDW-1:0]       winner_id,
    output logic [N_PLAYERS-1:0] winner_onehot,
    output logic                 timeout
`ifdef QUIZ_FALSE_START_EN
    ,
    output logic [N_PLAYERS-1:0] disq
`endif
);

    localparam int TW = clog2_safe(TIMEOUT_CYCLES + 1);

    state_t               state_q;
    state_t               state_d;
    logic [N_PLAYERS-1:0] sync_q [SYNC_STAGES];
    logic [N_PLAYERS-1:0] sync_prev;
    logic [N_PLAYERS-1:0] press;
    logic [N_PLAYERS-1:0] req;
    logic [N_PLAYERS-1:0] pick_onehot;
    logic [IDW-1:0]       pick_id;
    logic                 pick_any;
    logic [IDW-1:0]       ptr_q;
    logic [TW-1:0]        timer_q;
    logic                 timer_expire;
    logic                 lock_en;
    logic                 load_timer;
    logic [IDW-1:0]       id_q;
    logic [N_PLAYERS-1:0] onehot_q;

    // button synchroniser chain
    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= btn;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // edge history for rising-edge detect
    always_ff @(posedge clk or posedge preset) begin
        if (preset) sync_prev <= '0;
        else        sync_prev <= sync_q[SYNC_STAGES-1];
    end

    assign press = sync_q[SYNC_STAGES-1] & ~sync_prev;

`ifdef QUIZ_FALSE_START_EN
    logic [N_PLAYERS-1:0] disq_q;

    // latch false starts in IDLE, drop them when a round is closed
    always_ff @(posedge clk or posedge preset) begin
        if (preset)                           disq_q <= '0;
        else if (clear && state_q != ST_IDLE) disq_q <= '0;
        else if (state_q == ST_IDLE)          disq_q <= disq_q | press;
    end

    assign disq = disq_q;
    assign req  = press & ~disq_q;
`else
    assign req  = press;
`endif

    quiz_rr_pick #(
        .N   (N_PLAYERS),
        .IDW (IDW)
    ) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .gnt_onehot (pick_onehot),
        .gnt_id     (pick_id),
        .any        (pick_any)
    );

    assign timer_expire = (TIMEOUT_CYCLES != 0) && (timer_q == TW'(1));

    // state register
    always_ff @(posedge clk or posedge preset) begin
        if (preset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // next-state logic; clear overrides everything
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (arm) state_d = ST_ARMED;
                ST_ARMED: begin
                    if (pick_any)          state_d = ST_LOCKED;
                    else if (timer_expire) state_d = ST_TIMEOUT;
                end
                default:  state_d = state_q;
            endcase
        end
    end

    // output and strobe decode from the registered state
    always_comb begin
        winner_valid = 1'b0;
        timeout      = 1'b0;
        lock_en      = 1'b0;
        load_timer   = 1'b0;
        unique case (state_q)
            ST_IDLE:    load_timer   = arm && !clear;
            ST_ARMED:   lock_en      = pick_any && !clear;
            ST_LOCKED:  winner_valid = 1'b1;
            ST_TIMEOUT: timeout      = 1'b1;
            default:    winner_valid = 1'b0;
        endcase
    end

    // winner registers and rotating pointer
    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            id_q     <= '0;
            onehot_q <= '0;
            ptr_q    <= '0;
        end else if (clear) begin
            id_q     <= '0;
            onehot_q <= '0;
        end else if (lock_en) begin
            id_q     <= pick_id;
            onehot_q <= pick_onehot;
            ptr_q    <= (pick_id == IDW'(N_PLAYERS - 1)) ? '0
                                                         : pick_id + IDW'(1);
        end
    end

    // answer timer: loaded on arm, counts down while armed
    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            timer_q <= '0;
        end else if (load_timer) begin
            timer_q <= TW'(TIMEOUT_CYCLES);
        end else if (state_q == ST_ARMED && timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
        end
    end

    assign state         = state_q;
    assign winner_id     = id_q;
    assign winner_onehot = onehot_q;

endmodule
